// File: rtl/grayscale_pipe.sv
// Three-stage RGB-to-gray converter with a valid/ready stream interface,
// a dark-pixel threshold flag and a per-frame dark-pixel counter.
module grayscale_pipe #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 20
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVALID,
  output logic              oREADY,
  input  logic              iSOF,
  input  logic [DATA_W-1:0] iRed,
  input  logic [DATA_W-1:0] iGreen,
  input  logic [DATA_W-1:0] iBlue,
  input  logic [1:0]        iMODE,
  input  logic [7:0]        iCoefR,
  input  logic [7:0]        iCoefG,
  input  logic [7:0]        iCoefB,
  input  logic [DATA_W-1:0] iTHRESH,
  output logic              oVALID,
  input  logic              iREADY,
  output logic [DATA_W-1:0] oDATA,
  output logic              oBIN,
  output logic              oSOF,
  output logic [CNT_W-1:0]  oFRAME_DARK
);

  localparam int PROD_W = DATA_W + 8;
  localparam int SUM_W  = DATA_W + 10;
  localparam logic [DATA_W-1:0] GRAY_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  function automatic logic [SUM_W-1:0] round_half_up(input logic [SUM_W-1:0] s);
    return (s + SUM_W'(128)) >> 8;
  endfunction

  function automatic logic [DATA_W-1:0] sat_gray(input logic [SUM_W-1:0] v);
    if (v > SUM_W'(GRAY_MAX)) return GRAY_MAX;
    return v[DATA_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic b);
    if (b && (c != CNT_MAX)) return c + CNT_W'(1);
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] max3(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  logic en;
  assign en     = iREADY | ~oVALID;
  assign oREADY = en;

  // Weight selection: the max and green modes bypass the arithmetic path.
  logic [7:0]        wr_d, wg_d, wb_d;
  logic [DATA_W-1:0] sel_d;
  always_comb begin
    wr_d  = '0;
    wg_d  = '0;
    wb_d  = '0;
    sel_d = '0;
    case (iMODE)
      2'd0: begin
        wr_d = 8'd77;
        wg_d = 8'd151;
        wb_d = 8'd28;
      end
      2'd1: begin
        wr_d = iCoefR;
        wg_d = iCoefG;
        wb_d = iCoefB;
      end
      2'd2:    sel_d = max3(iRed, iGreen, iBlue);
      default: sel_d = iGreen;
    endcase
  end

  // ---- stage p1: weighted products / bypass select ----
  logic              vld_p1_q, sof_p1_q, use_sel_p1_q;
  logic [DATA_W-1:0] thr_p1_q, sel_p1_q;
  logic [PROD_W-1:0] prod_r_p1_q, prod_g_p1_q, prod_b_p1_q;

  // ---- stage p2: full-width sum ----
  logic              vld_p2_q, sof_p2_q, use_sel_p2_q;
  logic [DATA_W-1:0] thr_p2_q, sel_p2_q;
  logic [SUM_W-1:0]  sum_p2_q;

  // ---- stage p3: round, saturate, threshold ----
  logic              vld_p3_q, sof_p3_q, bin_p3_q;
  logic [DATA_W-1:0] data_p3_q;

  logic [DATA_W-1:0] gray_d;
  logic              bin_d;
  always_comb begin
    gray_d = use_sel_p2_q ? sel_p2_q : sat_gray(round_half_up(sum_p2_q));
    bin_d  = gray_d < thr_p2_q;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      vld_p3_q  <= 1'b0;
      sof_p3_q  <= 1'b0;
      bin_p3_q  <= 1'b0;
      data_p3_q <= '0;
    end else if (en) begin
      vld_p1_q  <= iVALID;
      vld_p2_q  <= vld_p1_q;
      vld_p3_q  <= vld_p2_q;
      sof_p3_q  <= sof_p2_q;
      bin_p3_q  <= bin_d;
      data_p3_q <= gray_d;
    end
  end

  // Datapath registers carry no reset; their valids gate any use.
  always_ff @(posedge iCLK) begin
    if (en) begin
      sof_p1_q     <= iSOF;
      use_sel_p1_q <= iMODE[1];
      thr_p1_q     <= iTHRESH;
      sel_p1_q     <= sel_d;
      prod_r_p1_q  <= PROD_W'(wr_d) * PROD_W'(iRed);
      prod_g_p1_q  <= PROD_W'(wg_d) * PROD_W'(iGreen);
      prod_b_p1_q  <= PROD_W'(wb_d) * PROD_W'(iBlue);
      sof_p2_q     <= sof_p1_q;
      use_sel_p2_q <= use_sel_p1_q;
      thr_p2_q     <= thr_p1_q;
      sel_p2_q     <= sel_p1_q;
      sum_p2_q     <= SUM_W'(prod_r_p1_q) + SUM_W'(prod_g_p1_q) + SUM_W'(prod_b_p1_q);
    end
  end

  assign oVALID = vld_p3_q;
  assign oDATA  = data_p3_q;
  assign oBIN   = bin_p3_q;
  assign oSOF   = sof_p3_q;

  // Dark-pixel counter: a SOF pixel publishes the previous frame's count.
  logic             xfer_out;
  logic [CNT_W-1:0] cnt_q, cnt_d, frame_q, frame_d;
  assign xfer_out = vld_p3_q & iREADY;

  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (xfer_out) begin
      if (sof_p3_q) begin
        frame_d = cnt_q;
        cnt_d   = CNT_W'(bin_p3_q);
      end else begin
        cnt_d = sat_inc(cnt_q, bin_p3_q);
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign oFRAME_DARK = frame_q;

endmodule

// File: tb/tb_grayscale_pipe.sv
// Directed bench for grayscale_pipe: vector table for the conversion modes,
// plus sequences for backpressure, frame counting and mid-stream reset.
module tb_grayscale_pipe;

  localparam int DW = 10;
  localparam int CW = 20;

  logic          iCLK = 1'b0;
  logic          iRST, iVALID, iSOF, iREADY;
  logic [DW-1:0] iRed, iGreen, iBlue, iTHRESH;
  logic [1:0]    iMODE;
  logic [7:0]    iCoefR, iCoefG, iCoefB;
  logic          oREADY, oVALID, oBIN, oSOF;
  logic [DW-1:0] oDATA;
  logic [CW-1:0] oFRAME_DARK;

  grayscale_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .oREADY(oREADY), .iSOF(iSOF),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue), .iMODE(iMODE),
    .iCoefR(iCoefR), .iCoefG(iCoefG), .iCoefB(iCoefB), .iTHRESH(iTHRESH),
    .oVALID(oVALID), .iREADY(iREADY), .oDATA(oDATA), .oBIN(oBIN), .oSOF(oSOF),
    .oFRAME_DARK(oFRAME_DARK)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [1:0] mode;
    int r, g, b, cr, cg, cb, thr, gray;
    logic bin;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  int tests = 0;
  int fails = 0;
  int sent, got, tmp;
  logic acc, hv, stall_now;
  logic [DW-1:0] held;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    iVALID = 1'b0;
    iSOF   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge iCLK); #1;
    end
  endtask

  task automatic push(input int g, input int thr, input logic sof);
    iVALID  = 1'b1;
    iREADY  = 1'b1;
    iMODE   = 2'd3;
    iRed    = '0;
    iBlue   = '0;
    iGreen  = g[DW-1:0];
    iTHRESH = thr[DW-1:0];
    iSOF    = sof;
    @(posedge iCLK); #1;
    iVALID = 1'b0;
    iSOF   = 1'b0;
  endtask

  initial begin
    //             mode  R     G     B     cR   cG   cB   thr   gray  bin
    vecs[0]  = '{2'd0, 1000, 0,    0,    0,   0,   0,   0,    301,  1'b0};
    vecs[1]  = '{2'd0, 1023, 1023, 1023, 0,   0,   0,   1023, 1023, 1'b0};
    vecs[2]  = '{2'd1, 1023, 1023, 1023, 255, 255, 255, 0,    1023, 1'b0};
    vecs[3]  = '{2'd1, 1023, 1023, 1023, 0,   0,   0,   1,    0,    1'b1};
    vecs[4]  = '{2'd2, 100,  700,  300,  0,   0,   0,   701,  700,  1'b1};
    vecs[5]  = '{2'd3, 100,  700,  300,  0,   0,   0,   700,  700,  1'b0};
    vecs[6]  = '{2'd2, 900,  5,    5,    0,   0,   0,   0,    900,  1'b0};
    vecs[7]  = '{2'd3, 900,  5,    5,    0,   0,   0,   6,    5,    1'b1};
    vecs[8]  = '{2'd1, 512,  256,  128,  128, 64,  32,  500,  336,  1'b1};
    vecs[9]  = '{2'd0, 0,    100,  0,    0,   0,   0,   60,   59,   1'b1};
    vecs[10] = '{2'd0, 0,    0,    1000, 0,   0,   0,   0,    109,  1'b0};
    vecs[11] = '{2'd1, 128,  0,    0,    1,   0,   0,   2,    1,    1'b1};
    vecs[12] = '{2'd1, 127,  0,    0,    1,   0,   0,   0,    0,    1'b0};

    iRST = 1'b1; iVALID = 1'b1; iSOF = 1'b1; iREADY = 1'b1; iMODE = 2'd3;
    iRed = 10'd5; iGreen = 10'd5; iBlue = 10'd5; iTHRESH = 10'd100;
    iCoefR = '0; iCoefG = '0; iCoefB = '0;

    // Reset state, with junk inputs presented during reset
    @(posedge iCLK); #1;
    chk("rst_ovalid", oVALID, 0);
    chk("rst_oready", oREADY, 1);
    chk("rst_odata", oDATA, 0);
    chk("rst_obin", oBIN, 0);
    chk("rst_osof", oSOF, 0);
    chk("rst_frame_dark", oFRAME_DARK, 0);
    @(posedge iCLK); #1;
    iRST = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_inputs_discarded", oVALID, 0);
      @(posedge iCLK); #1;
    end

    // Table of conversion vectors, streamed back-to-back
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) begin
        iVALID  = 1'b1;
        iSOF    = 1'b0;
        iMODE   = vecs[c].mode;
        iRed    = vecs[c].r[DW-1:0];
        iGreen  = vecs[c].g[DW-1:0];
        iBlue   = vecs[c].b[DW-1:0];
        iCoefR  = vecs[c].cr[7:0];
        iCoefG  = vecs[c].cg[7:0];
        iCoefB  = vecs[c].cb[7:0];
        iTHRESH = vecs[c].thr[DW-1:0];
      end else begin
        iVALID = 1'b0;
      end
      @(posedge iCLK); #1;
      if (c >= 2) begin
        chk("vec_valid", oVALID, 1);
        chk("vec_gray", oDATA, vecs[c-2].gray);
        chk("vec_bin", oBIN, vecs[c-2].bin);
      end else begin
        chk("vec_latency", oVALID, 0);
      end
    end
    idle(4);

    // Backpressure: five pixels, downstream stalls on loop cycles 4 and 5
    sent = 0; got = 0;
    for (int c = 0; c < 20; c++) begin
      iREADY  = !(c == 4 || c == 5);
      iVALID  = (sent < 5);
      iMODE   = 2'd3;
      iSOF    = 1'b0;
      iTHRESH = '0;
      tmp     = 10 * (sent + 1);
      iGreen  = tmp[DW-1:0];
      #1;
      acc = iVALID && oREADY;
      if (!iREADY) chk("stall_oready", oREADY, 0);
      if (oVALID && iREADY) begin
        chk("stream_order", oDATA, 10 * (got + 1));
        got++;
      end
      held = oDATA; hv = oVALID; stall_now = !iREADY;
      @(posedge iCLK); #1;
      if (acc) sent++;
      if (stall_now && hv) begin
        chk("stall_hold_valid", oVALID, 1);
        chk("stall_hold_data", oDATA, held);
      end
    end
    chk("stream_count", got, 5);
    iREADY = 1'b1;
    idle(3);

    // Frame dark counting
    push(100, 200, 1'b1);
    push(300, 200, 1'b0);
    push(150, 200, 1'b0);
    push(50, 200, 1'b1);
    idle(5);
    chk("frame_dark_a", oFRAME_DARK, 2);
    push(500, 200, 1'b1);
    idle(2);
    chk("sof_pixel_valid", oVALID, 1);
    chk("sof_pixel_sof", oSOF, 1);
    chk("sof_pixel_data", oDATA, 500);
    chk("sof_pixel_bin", oBIN, 0);
    idle(3);
    chk("frame_dark_b", oFRAME_DARK, 1);

    // Reset with pixels in flight
    push(11, 0, 1'b0);
    push(22, 0, 1'b0);
    push(33, 0, 1'b0);
    iRST = 1'b1; iVALID = 1'b1;
    @(posedge iCLK); #1;
    chk("midrst_ovalid", oVALID, 0);
    chk("midrst_frame_dark", oFRAME_DARK, 0);
    chk("midrst_oready", oREADY, 1);
    iRST = 1'b0;
    iVALID = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge iCLK); #1;
      chk("midrst_no_stale", oVALID, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
